// File: rtl/slow_fast_sync_pkg.sv
// -----------------------------------------------------------------------------
// slow_fast_sync_pkg
// Shared definitions for the slow-to-fast data synchronizer:
//   - sync_state_t          : capture FSM states
//   - CNT_W                 : width of the settle counter
//   - DATA_BUS_SIZE_DEFAULT : default data bus width
//   - SETTLE_CYCLES_DEFAULT : default settle wait (clk cycles)
// -----------------------------------------------------------------------------
package slow_fast_sync_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } sync_state_t;

   localparam int CNT_W                 = 4;
   localparam int DATA_BUS_SIZE_DEFAULT = 24;
   localparam int SETTLE_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/clk_edge_detect.sv
// -----------------------------------------------------------------------------
// clk_edge_detect
// Samples slow_clk as an asynchronous data signal. It is never used as a
// clock. Then it produces a one-clk-cycle pulse on each qualified rising edge.
// Ports:
//   clk      in  : fast clock
//   reset    in  : synchronous active-high reset
//   slow_clk in  : slow-domain clock, treated as async data
//   rise     out : single-cycle pulse, synchronized slow_clk rose
// -----------------------------------------------------------------------------
module clk_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic slow_clk,
   output logic rise
);

   logic       sync1_reg;
   logic       sync2_reg;
   logic       prev_reg;
   logic       armed_reg;
   // Marks when sync2_reg holds a real sample rather than its reset value.
   // Without this, a slow_clk that is high across reset release would look
   // like a 0 -> 1 transition and arm the detector falsely.
   logic [1:0] fill_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
         armed_reg <= 1'b0;
         fill_reg  <= 2'b00;
      end else begin
         sync1_reg <= slow_clk;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         fill_reg  <= {fill_reg[0], 1'b1};
         if (fill_reg[1] && !sync2_reg)
            armed_reg <= 1'b1;
      end
   end

   assign rise = sync2_reg & ~prev_reg & armed_reg;

endmodule

// File: rtl/slow_to_fast_data_sync.sv
// -----------------------------------------------------------------------------
// slow_to_fast_data_sync
// Captures a word launched on slow_clk rising edges into the clk domain. It
// waits settle_cycles clk cycles after each detected edge, then registers
// the word and raises a valid level. The valid level stays up until the
// consumer acknowledges the word.
// Parameters:
//   data_bus_size : data width (default 24)
//   settle_cycles : settle wait after a detected edge, 1..15 (default 2)
// Ports:
//   clk           in  : fast clock, only clock
//   reset         in  : synchronous active-high reset
//   slow_clk      in  : slow-domain clock, sampled as data
//   in_data_async in  : slow-domain data, stable for one slow period
//   out_data_sync out : captured word (registered)
//   out_valid     out : a captured word is pending
//   out_ack       in  : consumer accepts out_data_sync
//   overrun       out : sticky, an unacknowledged word was overwritten
//   overrun_clr   in  : clears overrun
// Build option:
//   SLOW_FAST_OVERRUN_DETECT_EN : when defined, implements overrun
//   detection. Otherwise overrun is tied to 0 and overrun_clr is ignored.
// -----------------------------------------------------------------------------
module slow_to_fast_data_sync
   import slow_fast_sync_pkg::*;
#(
   parameter int data_bus_size = DATA_BUS_SIZE_DEFAULT,
   parameter int settle_cycles = SETTLE_CYCLES_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     slow_clk,
   input  logic [data_bus_size-1:0] in_data_async,
   output logic [data_bus_size-1:0] out_data_sync,
   output logic                     out_valid,
   input  logic                     out_ack,
   output logic                     overrun,
   input  logic                     overrun_clr
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(settle_cycles - 1);

   logic                     rise;
   sync_state_t              state_reg;
   sync_state_t              state_next;
   logic [CNT_W-1:0]         cnt_reg;
   logic [CNT_W-1:0]         cnt_next;
   logic                     capture;
   logic [data_bus_size-1:0] data_reg;
   logic                     valid_reg;

   clk_edge_detect u_edge (
      .clk      (clk),
      .reset    (reset),
      .slow_clk (slow_clk),
      .rise     (rise)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Only IDLE listens to rise. Edges that arrive while a capture is in
   // progress are dropped.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rise) begin
               state_next = SETTLE;
               cnt_next   = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (cnt_reg == '0)
               state_next = CAPTURE;
            else
               cnt_next = cnt_reg - CNT_W'(1);
         end
         CAPTURE: begin
            capture    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A capture takes priority over an acknowledge in the same cycle, so the
   // newest word is never lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg  <= '0;
         valid_reg <= 1'b0;
      end else if (capture) begin
         data_reg  <= in_data_async;
         valid_reg <= 1'b1;
      end else if (valid_reg && out_ack) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_data_sync = data_reg;
   assign out_valid     = valid_reg;

`ifdef SLOW_FAST_OVERRUN_DETECT_EN
   logic overrun_reg;
   logic overrun_set;

   // A pending word that is acked on the capture cycle is not counted as
   // lost.
   assign overrun_set = capture & valid_reg & ~out_ack;

   always_ff @(posedge clk) begin
      if (reset)
         overrun_reg <= 1'b0;
      else if (overrun_set)
         overrun_reg <= 1'b1;
      else if (overrun_clr)
         overrun_reg <= 1'b0;
   end

   assign overrun = overrun_reg;
`else
   logic unused_overrun_clr;
   assign unused_overrun_clr = overrun_clr;
   assign overrun            = 1'b0;
`endif

endmodule

// File: tb/tb_slow_to_fast_data_sync.sv
// -----------------------------------------------------------------------------
// tb_slow_to_fast_data_sync
// Directed bench for slow_to_fast_data_sync with default parameters
// (24-bit bus, settle_cycles = 2). The slow clock has a 40 clk period.
// -----------------------------------------------------------------------------
module tb_slow_to_fast_data_sync;

`ifdef SLOW_FAST_OVERRUN_DETECT_EN
   localparam logic EXP_OVR = 1'b1;
`else
   localparam logic EXP_OVR = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        slow_clk;
   logic [23:0] in_data_async;
   logic [23:0] out_data_sync;
   logic        out_valid;
   logic        out_ack;
   logic        overrun;
   logic        overrun_clr;

   int n_cmp = 0;
   int n_bad = 0;

   slow_to_fast_data_sync #(
      .data_bus_size (24),
      .settle_cycles (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .slow_clk      (slow_clk),
      .in_data_async (in_data_async),
      .out_data_sync (out_data_sync),
      .out_valid     (out_valid),
      .out_ack       (out_ack),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running required done");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; slow_clk = 1'b0; in_data_async = '0;
      out_ack = 1'b0; overrun_clr = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b required 0", out_valid); end
      n_cmp++;
      if (out_data_sync !== 24'h0) begin n_bad++; $display("FAIL reset_data got %h required 000000", out_data_sync); end
      n_cmp++;
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b required 0", overrun); end
      reset = 1'b0;
      repeat (5) tick();
      $display("reset: valid=%b data=%h overrun=%b", out_valid, out_data_sync, overrun);
   endtask

   // The first posedge after the drive samples slow_clk high. Valid must
   // appear after the 6th posedge (5 edges later) and not before.
   task automatic test_latency();
      slow_clk = 1'b1; in_data_async = 24'hA5A5A5;
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk); #1;
         if (e == 5) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_early got valid=%b required 0", out_valid); end
         end
         if (e == 6) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_valid got %b required 1", out_valid); end
            n_cmp++;
            if (out_data_sync !== 24'hA5A5A5) begin n_bad++; $display("FAIL latency_data got %h required a5a5a5", out_data_sync); end
         end
      end
      $display("latency: word %h valid=%b", out_data_sync, out_valid);
      tick();
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_ack_clear got %b required 0", out_valid); end
      repeat (12) tick();
      slow_clk = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_stream();
      int  delivered;
      int  t;
      bit  seen;
      delivered = 0;
      for (int k = 1; k <= 8; k++) begin
         slow_clk = 1'b1; in_data_async = 24'(k);
         t = 0; seen = 1'b0;
         while (!seen && t < 15) begin
            tick(); t++;
            if (out_valid === 1'b1) seen = 1'b1;
         end
         n_cmp++;
         if (!seen) begin
            n_bad++; $display("FAIL stream_timeout word %0d got no valid required valid", k);
         end else begin
            n_cmp++;
            if (out_data_sync !== 24'(k)) begin
               n_bad++; $display("FAIL stream_data got %h required %h", out_data_sync, 24'(k));
            end else begin
               delivered++;
            end
            $display("stream: word %0d data=%h after %0d cycles", k, out_data_sync, t);
            tick(); out_ack = 1'b1; tick(); out_ack = 1'b0; t += 2;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_ack_clear got %b required 0", out_valid); end
         end
         repeat (20 - t) tick();
         slow_clk = 1'b0;
         repeat (20) tick();
      end
      n_cmp++;
      if (delivered != 8) begin n_bad++; $display("FAIL stream_count got %0d required 8", delivered); end
      n_cmp++;
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL stream_overrun got %b required 0", overrun); end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 2; i++) begin
         slow_clk = 1'b1; in_data_async = (i == 0) ? 24'd11 : 24'd22;
         repeat (20) tick();
         slow_clk = 1'b0;
         repeat (20) tick();
      end
      $display("overrun: data=%0d valid=%b overrun=%b", out_data_sync, out_valid, overrun);
      n_cmp++;
      if (out_data_sync !== 24'd22) begin n_bad++; $display("FAIL overrun_newest got %0d required 22", out_data_sync); end
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL overrun_valid got %b required 1", out_valid); end
      n_cmp++;
      if (overrun !== EXP_OVR) begin n_bad++; $display("FAIL overrun_set got %b required %b", overrun, EXP_OVR); end
      repeat (3) tick();
      n_cmp++;
      if (overrun !== EXP_OVR) begin n_bad++; $display("FAIL overrun_sticky got %b required %b", overrun, EXP_OVR); end
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      n_cmp++;
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clr got %b required 0", overrun); end
      // The clear coincides with a fresh overwrite, so the set must win.
      slow_clk = 1'b1; in_data_async = 24'd33;
      repeat (5) tick();
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      $display("overrun: clr with set, data=%0d overrun=%b", out_data_sync, overrun);
      n_cmp++;
      if (out_data_sync !== 24'd33) begin n_bad++; $display("FAIL overrun_coincide_data got %0d required 33", out_data_sync); end
      n_cmp++;
      if (overrun !== EXP_OVR) begin n_bad++; $display("FAIL overrun_set_wins got %b required %b", overrun, EXP_OVR); end
      overrun_clr = 1'b1; out_ack = 1'b1; tick(); overrun_clr = 1'b0; out_ack = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_ack_clear got %b required 0", out_valid); end
      repeat (13) tick();
      slow_clk = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_ack_on_capture();
      slow_clk = 1'b1; in_data_async = 24'h000044;
      repeat (20) tick();
      slow_clk = 1'b0;
      repeat (20) tick();
      slow_clk = 1'b1; in_data_async = 24'h000055;
      repeat (5) tick();
      n_cmp++;
      if (out_data_sync !== 24'h000044) begin n_bad++; $display("FAIL ackcap_before got %h required 000044", out_data_sync); end
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      $display("ack_on_capture: data=%h valid=%b overrun=%b", out_data_sync, out_valid, overrun);
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ackcap_valid got %b required 1", out_valid); end
      n_cmp++;
      if (out_data_sync !== 24'h000055) begin n_bad++; $display("FAIL ackcap_data got %h required 000055", out_data_sync); end
      n_cmp++;
      if (overrun !== 1'b0) begin n_bad++; $display("FAIL ackcap_overrun got %b required 0", overrun); end
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ackcap_clear got %b required 0", out_valid); end
      repeat (13) tick();
      slow_clk = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_reset_mid_settle();
      int vcount;
      int t;
      vcount = 0;
      slow_clk = 1'b1; in_data_async = 24'h000066;
      repeat (3) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); if (out_valid === 1'b1) vcount++; end
      slow_clk = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); if (out_valid === 1'b1) vcount++; end
      $display("reset_mid_settle: valid cycles after abort=%0d", vcount);
      n_cmp++;
      if (vcount != 0) begin n_bad++; $display("FAIL midsettle_no_valid got %0d valid cycles required 0", vcount); end
      slow_clk = 1'b1; in_data_async = 24'h000077;
      t = 0;
      while (out_valid !== 1'b1 && t < 15) begin tick(); t++; end
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midsettle_recover got valid=%b required 1", out_valid); end
      n_cmp++;
      if (out_data_sync !== 24'h000077) begin n_bad++; $display("FAIL midsettle_data got %h required 000077", out_data_sync); end
      $display("reset_mid_settle: recovered word %h after %0d cycles", out_data_sync, t);
      out_ack = 1'b1; tick(); out_ack = 1'b0; t++;
      repeat (20 - t) tick();
      slow_clk = 1'b0;
      repeat (20) tick();
   endtask

   task automatic test_reset_release_high();
      int vcount;
      vcount = 0;
      reset = 1'b1; slow_clk = 1'b1; in_data_async = 24'h000099;
      repeat (3) tick();
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); if (out_valid === 1'b1) vcount++; end
      slow_clk = 1'b0;
      for (int i = 0; i < 20; i++) begin tick(); if (out_valid === 1'b1) vcount++; end
      n_cmp++;
      if (vcount != 0) begin n_bad++; $display("FAIL release_high_no_capture got %0d valid cycles required 0", vcount); end
      slow_clk = 1'b1; in_data_async = 24'h000088;
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk); #1;
         if (e == 5) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_latency_early got %b required 0", out_valid); end
         end
         if (e == 6) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL release_latency_valid got %b required 1", out_valid); end
            n_cmp++;
            if (out_data_sync !== 24'h000088) begin n_bad++; $display("FAIL release_latency_data got %h required 000088", out_data_sync); end
         end
      end
      $display("reset_release_high: first word %h valid=%b", out_data_sync, out_valid);
      tick();
      out_ack = 1'b1; tick(); out_ack = 1'b0;
      repeat (12) tick();
      slow_clk = 1'b0;
      repeat (20) tick();
   endtask

   initial begin
      test_reset();
      test_latency();
      test_stream();
      test_overrun();
      test_ack_on_capture();
      test_reset_mid_settle();
      test_reset_release_high();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
